// File: rtl/avg_ctrl.sv
`timescale 1ns/1ps
// avg_ctrl: sequencing controller for an external 8-sample moving averager.
//
// Accepts samples over a valid/ready handshake, feeds each one to the
// averager (avg_num + a one-cycle avg_step), waits for the averager result
// and hands it downstream over a second valid/ready handshake. A window
// holds 8 samples: no result is produced until the 8th sample after a clear.
// flush (or reset) clears the window via avg_rs and drops anything in flight.
//
// Ports:
//   clk, rs              clock, asynchronous active-high reset
//   in_valid/in_data/in_ready     sample input handshake
//   flush                level request to clear the averaging window
//   avg_num/avg_step/avg_rs       drive the averager's num_in, step, reset
//   avg_ave8             averager result (valid the cycle after avg_step)
//   out_valid/out_data/out_ready  result output handshake
//   fill_cnt             samples in window, 0..8 saturating
//   busy                 clearing, a sample in flight, or a result held
//
// Build option:
//   AVG_CTRL_DECIM_EN    when defined, only samples 8, 16, 24, ... after a
//                        clear produce a result (decimate by 8).
module avg_ctrl (
    input  logic       clk,
    input  logic       rs,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       flush,
    output logic [7:0] avg_num,
    output logic       avg_step,
    output logic       avg_rs,
    input  logic [7:0] avg_ave8,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic [3:0] fill_cnt,
    output logic       busy
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WIN    = 8;

    typedef enum logic [1:0] {
        ST_CLR  = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t state;
    logic   cap_pend;   // averager result is valid this cycle
    logic   step_emit;  // sample currently stepping will produce a result
    logic   cap_emit;   // pending capture will produce a result
    logic   accept;
    logic   emit_c;     // the sample being accepted now will produce a result

`ifdef AVG_CTRL_DECIM_EN
    logic [2:0] dec_cnt;  // accepted samples modulo 8 since the last clear
`endif

    // Sample acceptance: only when the pipeline and output stage are free.
    assign in_ready = ((state == ST_FILL) || (state == ST_RUN)) && !flush &&
                      !avg_step && !cap_pend && !(out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == ST_CLR) || avg_step || cap_pend || out_valid;

    // Result decision for the sample being accepted (fill_cnt is pre-increment).
`ifdef AVG_CTRL_DECIM_EN
    assign emit_c = (dec_cnt == 3'd7);
`else
    assign emit_c = (fill_cnt >= CNT_W'(WIN - 1));
`endif

    // Control FSM with its registered outputs and datapath.
    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            state     <= ST_CLR;
            avg_rs    <= 1'b1;
            avg_step  <= 1'b0;
            avg_num   <= '0;
            cap_pend  <= 1'b0;
            step_emit <= 1'b0;
            cap_emit  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            fill_cnt  <= '0;
`ifdef AVG_CTRL_DECIM_EN
            dec_cnt   <= '0;
`endif
        end else begin
            case (state)
                ST_CLR: begin
                    // Hold the averager in reset; a held flush restarts the clear.
                    avg_step  <= 1'b0;
                    cap_pend  <= 1'b0;
                    step_emit <= 1'b0;
                    cap_emit  <= 1'b0;
                    out_valid <= 1'b0;
                    fill_cnt  <= '0;
`ifdef AVG_CTRL_DECIM_EN
                    dec_cnt   <= '0;
`endif
                    if (flush) begin
                        state  <= ST_CLR;
                        avg_rs <= 1'b1;
                    end else begin
                        state  <= ST_FILL;
                        avg_rs <= 1'b0;
                    end
                end

                ST_FILL, ST_RUN: begin
                    if (flush) begin
                        // Drop everything in flight and clear the window.
                        state     <= ST_CLR;
                        avg_rs    <= 1'b1;
                        avg_step  <= 1'b0;
                        cap_pend  <= 1'b0;
                        step_emit <= 1'b0;
                        cap_emit  <= 1'b0;
                        out_valid <= 1'b0;
                        fill_cnt  <= '0;
`ifdef AVG_CTRL_DECIM_EN
                        dec_cnt   <= '0;
`endif
                    end else begin
                        // step -> cap_pend -> capture, one stage per cycle.
                        avg_step <= accept;
                        cap_pend <= avg_step;
                        cap_emit <= step_emit;

                        if (accept) begin
                            avg_num   <= in_data;
                            step_emit <= emit_c;
                            if (fill_cnt != CNT_W'(WIN))
                                fill_cnt <= fill_cnt + CNT_W'(1);
`ifdef AVG_CTRL_DECIM_EN
                            dec_cnt   <= dec_cnt + 3'd1;
`endif
                            if ((state == ST_FILL) && (fill_cnt == CNT_W'(WIN - 1)))
                                state <= ST_RUN;
                        end

                        // A capture wins over a same-edge downstream handshake.
                        if (cap_pend && cap_emit) begin
                            out_data  <= DATA_W'(avg_ave8);
                            out_valid <= 1'b1;
                        end else if (out_ready) begin
                            out_valid <= 1'b0;
                        end
                    end
                end

                default: begin
                    state  <= ST_CLR;
                    avg_rs <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avg_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for avg_ctrl: a behavioural 8-sample moving averager
// stands in for the external block; directed tables and sequences cover the
// handshake corners, and a random phase is scored against a window model.
module tb_avg_ctrl;

    logic       clk = 1'b0;
    logic       rs;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       flush;
    logic [7:0] avg_num;
    logic       avg_step;
    logic       avg_rs;
    logic [7:0] avg_ave8;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [3:0] fill_cnt;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;

    always #5 clk = ~clk;

    avg_ctrl dut (
        .clk       (clk),
        .rs        (rs),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .flush     (flush),
        .avg_num   (avg_num),
        .avg_step  (avg_step),
        .avg_rs    (avg_rs),
        .avg_ave8  (avg_ave8),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .fill_cnt  (fill_cnt),
        .busy      (busy)
    );

    // Stand-in averager: floor of the sum of the last 8 samples / 8.
    logic [7:0] win [8];

    function automatic int win_sum7();
        int s = 0;
        for (int i = 0; i < 7; i++) s += int'(win[i]);
        return s;
    endfunction

    always @(posedge clk) begin
        if (avg_rs) begin
            for (int i = 0; i < 8; i++) win[i] <= 8'd0;
            avg_ave8 <= 8'd0;
        end else if (avg_step) begin
            for (int i = 7; i > 0; i--) win[i] <= win[i-1];
            win[0]   <= avg_num;
            avg_ave8 <= 8'((win_sum7() + int'(avg_num)) / 8);
        end
    end

    // Directed vector table.
    typedef struct {
        bit         flush_first;
        logic [7:0] data;
        bit         exp_out;
        logic [7:0] exp_val;
        logic [3:0] exp_fill;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit f, int d, bit eo, int ev, int fc);
        vec_t v;
        v.flush_first = f;
        v.data        = 8'(d);
        v.exp_out     = eo;
        v.exp_val     = 8'(ev);
        v.exp_fill    = 4'(fc);
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_pt();
        @(posedge clk);
        #1;
    endtask

    // Present a sample until it is accepted; returns 1ns after the accept edge.
    task automatic send(input logic [7:0] d);
        bit ok = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            drive_pt();
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready never seen for data %0d", d);
        end
    endtask

    // Send one sample and check the pipeline cycle by cycle up to the result.
    task automatic send_chk(input logic [7:0] d, input bit eo, input logic [7:0] ev,
                            input logic [3:0] ef, input string tag);
        send(d);
        @(negedge clk);
        chk({tag, "_step"},     32'(avg_step),  1);
        chk({tag, "_num"},      32'(avg_num),   32'(d));
        chk({tag, "_fill"},     32'(fill_cnt),  32'(ef));
        chk({tag, "_rdy_blk"},  32'(in_ready),  0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_early"},    32'(out_valid), 0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_ovalid"},   32'(out_valid), 32'(eo));
        if (out_valid) n_out++;
        if (eo) chk({tag, "_odata"}, 32'(out_data), 32'(ev));
        drive_pt();
    endtask

    // Single-cycle flush pulse; avg_rs must be high for exactly one cycle.
    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready), 0);
        drive_pt();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_avg_rs",   32'(avg_rs),    1);
        chk("flush_fill",     32'(fill_cnt),  0);
        chk("flush_ovalid",   32'(out_valid), 0);
        chk("flush_busy",     32'(busy),      1);
        drive_pt();
        @(negedge clk);
        chk("flush_avg_rs_off", 32'(avg_rs),  0);
        drive_pt();
    endtask

    // Random-phase reference: accepted samples since the last clear.
    logic [7:0] mwin[$];
    logic [7:0] exp_q[$];
    int         mcount;

    function automatic bit model_emit(int cnt);
`ifdef AVG_CTRL_DECIM_EN
        return (cnt % 8) == 0;
`else
        return cnt >= 8;
`endif
    endfunction

    task automatic mon_cycle();
        int s;
        @(negedge clk);
        chk("rand_fill", 32'(fill_cnt), 32'((mcount > 8) ? 8 : mcount));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rand_spurious: got output %0d, expected none", out_data);
            end else begin
                chk("rand_out", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
        if (in_valid && in_ready) begin
            mwin.push_back(in_data);
            if (mwin.size() > 8) void'(mwin.pop_front());
            mcount++;
            if (model_emit(mcount)) begin
                s = 0;
                foreach (mwin[i]) s += int'(mwin[i]);
                exp_q.push_back(8'(s / 8));
            end
        end
        if (flush) begin
            mwin.delete();
            exp_q.delete();
            mcount = 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rs        = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'd0;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Reset values, with in_valid asserted to show in_ready stays low.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_avg_rs",    32'(avg_rs),    1);
        chk("rst_avg_step",  32'(avg_step),  0);
        chk("rst_avg_num",   32'(avg_num),   0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data",  32'(out_data),  0);
        chk("rst_fill",      32'(fill_cnt),  0);
        chk("rst_in_ready",  32'(in_ready),  0);
        chk("rst_busy",      32'(busy),      1);
        drive_pt();
        rs       = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("clr_avg_rs",    32'(avg_rs),    1);
        chk("clr_in_ready",  32'(in_ready),  0);
        drive_pt();
        @(negedge clk);
        chk("fill_avg_rs",   32'(avg_rs),    0);
        chk("fill_in_ready", 32'(in_ready),  1);
        chk("fill_busy",     32'(busy),      0);
        drive_pt();

        // Table: 8 x 100, then the 133/124/102 sequence after a flush.
        for (int i = 1; i <= 8; i++) add(0, 100, i == 8, 100, i);
        add(1, 100, 0, 0, 1);
        add(0, 200, 0, 0, 2);
        add(0, 100, 0, 0, 3);
        add(0, 200, 0, 0, 4);
        add(0, 255, 0, 0, 5);
        add(0,  91, 0, 0, 6);
        add(0,  25, 0, 0, 7);
        add(0, 100, 1, 133, 8);
`ifdef AVG_CTRL_DECIM_EN
        add(0,  25, 0, 0, 8);
        add(0,  24, 0, 0, 8);
`else
        add(0,  25, 1, 124, 8);
        add(0,  24, 1, 102, 8);
`endif
        foreach (vecs[i]) begin
            if (vecs[i].flush_first) do_flush();
            send_chk(vecs[i].data, vecs[i].exp_out, vecs[i].exp_val,
                     vecs[i].exp_fill, $sformatf("vec%0d", i));
        end

        // Back-pressure: result held and input blocked until out_ready.
        do_flush();
        send_chk(100, 0, 0, 1, "bp1");
        send_chk(200, 0, 0, 2, "bp2");
        send_chk(100, 0, 0, 3, "bp3");
        send_chk(200, 0, 0, 4, "bp4");
        send_chk(255, 0, 0, 5, "bp5");
        send_chk( 91, 0, 0, 6, "bp6");
        send_chk( 25, 0, 0, 7, "bp7");
        out_ready = 1'b0;
        send(100);
        @(posedge clk);
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(out_valid), 1);
            chk("bp_hold_data",  32'(out_data),  133);
            chk("bp_hold_rdy",   32'(in_ready),  0);
        end
        drive_pt();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_rdy",   32'(in_ready),  1);
        chk("bp_release_valid", 32'(out_valid), 1);
        drive_pt();
        @(negedge clk);
        chk("bp_cleared", 32'(out_valid), 0);
        drive_pt();

        // Flush mid-fill, then a fresh window of 50s.
        do_flush();
        for (int i = 1; i <= 5; i++) send_chk(7, 0, 0, 4'(i), "pre_flush");
        do_flush();
        for (int i = 1; i <= 8; i++) send_chk(50, i == 8, 50, 4'(i), "post_flush");

        // Reset one cycle after the 8th accept: the result must never appear.
        do_flush();
        for (int i = 1; i <= 7; i++) send_chk(100, 0, 0, 4'(i), "rst_mid");
        send(100);
        drive_pt();
        rs = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstmid_ovalid", 32'(out_valid), 0);
            chk("rstmid_odata",  32'(out_data),  0);
            chk("rstmid_avg_rs", 32'(avg_rs),    1);
            chk("rstmid_step",   32'(avg_step),  0);
            chk("rstmid_num",    32'(avg_num),   0);
            chk("rstmid_fill",   32'(fill_cnt),  0);
            chk("rstmid_rdy",    32'(in_ready),  0);
            chk("rstmid_busy",   32'(busy),      1);
        end
        drive_pt();
        rs = 1'b0;
        @(negedge clk);
        chk("rstmid_clr", 32'(avg_rs), 1);
        drive_pt();
        @(negedge clk);
        chk("rstmid_fill_state", 32'(avg_rs),    0);
        chk("rstmid_no_out",     32'(out_valid), 0);
        drive_pt();

        // 16 samples of 10: decimated build gives outputs after 8 and 16 only.
        n_out = 0;
        for (int i = 1; i <= 16; i++) begin
`ifdef AVG_CTRL_DECIM_EN
            send_chk(10, (i % 8) == 0, 10, 4'((i > 8) ? 8 : i), "dec");
`else
            send_chk(10, i >= 8, 10, 4'((i > 8) ? 8 : i), "dec");
`endif
        end
`ifdef AVG_CTRL_DECIM_EN
        chk("dec_out_count", 32'(n_out), 2);
`else
        chk("dec_out_count", 32'(n_out), 9);
`endif

        // Random traffic with occasional flushes against the window model.
        do_flush();
        mcount = 0;
        mwin.delete();
        exp_q.delete();
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom % 3) != 0;
            in_data   = 8'($urandom);
            out_ready = ($urandom % 4) != 0;
            flush     = ($urandom % 150) == 0;
            mon_cycle();
            drive_pt();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            mon_cycle();
            drive_pt();
        end
        @(negedge clk);
        chk("drain_expected_left", 32'(exp_q.size()), 0);
        chk("drain_busy",          32'(busy),         0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/avg_ctrl.md
AVG_CTRL -- requirements
Module: avg_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  single clock, all state rising-edge.
REQ-002 SHALL have port: rs  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: in_valid in 1, in_data in 8, in_ready out 1  sample input, valid/ready handshake.
REQ-004 SHALL have port: flush  in  1  level request to clear the averaging window.
REQ-005 SHALL have ports: avg_num out 8, avg_step out 1, avg_rs out 1  drive the averager's num_in, step-enable and rs.
REQ-006 SHALL have port: avg_ave8  in  8  averager result, valid the cycle after an avg_step cycle.
REQ-007 SHALL have ports: out_valid out 1, out_data out 8, out_ready in 1  result output, valid/ready handshake.
REQ-008 SHALL have ports: fill_cnt out 4 (samples in window, 0..8, saturating) and busy out 1.

Function
REQ-009 SHALL implement states CLR, FILL, RUN; CLR lasts exactly one cycle with avg_rs=1, then FILL.
REQ-010 SHALL accept a sample on a cycle with in_valid && in_ready.
REQ-011 SHALL compute in_ready = (FILL or RUN) && !flush && !avg_step && !cap_pend && !(out_valid && !out_ready).
REQ-012 SHALL, on accept at edge N, register in_data into avg_num and hold avg_step=1 for the single cycle N..N+1.
REQ-013 SHALL hold avg_num stable when avg_step=0.
REQ-014 SHALL set cap_pend in the cycle after avg_step and capture avg_ave8 into out_data at the following edge.
REQ-015 SHALL raise out_valid 2 cycles after acceptance when the sample produces an output (REQ-017).
REQ-016 SHALL hold out_valid and out_data until out_ready=1; the out_valid && out_ready cycle clears out_valid unless a new capture occurs on the same edge.
REQ-017 SHALL produce an output for the 8th accepted sample after CLR and every later sample; samples 1-7 produce no output.
REQ-018 SHALL increment fill_cnt on each accept, saturating at 8; transition FILL->RUN on the accept making fill_cnt=8.
REQ-019 SHALL, on flush=1 in FILL or RUN, enter CLR next edge, drop any in-flight sample/result, clear out_valid, and zero fill_cnt.
REQ-020 SHALL treat flush in CLR as restarting CLR (avg_rs stays 1 while flush held).
REQ-021 SHALL drive busy = (state==CLR) || avg_step || cap_pend || out_valid.
REQ-022 SHALL pass avg_ave8 unmodified; averaging arithmetic (floor of 8-sample sum / 8) belongs to the averager.

Reset
REQ-023 SHALL, while rs=1, force state=CLR, avg_rs=1, avg_step=0, avg_num=0, cap_pend=0, out_valid=0, out_data=0, fill_cnt=0, in_ready=0, busy=1.
REQ-024 SHALL, on rs deassert, remain in CLR for one cycle then enter FILL.
REQ-025 SHALL abandon any in-flight sample or pending output when rs asserts mid-operation, with no output emitted.

Configuration
REQ-026 SHALL support macro AVG_CTRL_DECIM_EN.
REQ-027 SHALL, with AVG_CTRL_DECIM_EN defined, produce outputs only for accepted samples 8, 16, 24, ... after CLR (3-bit modulo counter, cleared by CLR).
REQ-028 SHALL, without AVG_CTRL_DECIM_EN, produce outputs per REQ-017.

Verification
REQ-029 SHALL cover: reset, then 8 samples of 100 with out_ready=1 -> no out_valid for samples 1-7; out_data=100 two cycles after the 8th accept.
REQ-030 SHALL cover: samples 100,200,100,200,255,91,25,100 -> single output 133; then 25 -> 124; then 24 -> 102 (non-decim).
REQ-031 SHALL cover: out_ready=0 after the 8th sample -> out_valid/out_data=133 held, in_ready=0 until out_ready=1.
REQ-032 SHALL cover: flush after 5 samples -> avg_rs=1 for one cycle, fill_cnt=0; 8 new samples of 50 -> output 50.
REQ-033 SHALL cover: rs asserted one cycle after the 8th accept -> no out_valid, all outputs at reset values.
REQ-034 SHALL cover, with AVG_CTRL_DECIM_EN: 16 samples of 10 -> exactly 2 outputs, both 10, after samples 8 and 16.
